// File: rtl/instr_sequencer_if.sv
// Interface between the instruction sequencer, program memory and the control unit (cu).
// Handshake: the sequencer raises instr_valid for exactly one cycle when instr holds a new
// word for the cu. The cu answers with a one-cycle cu_done pulse when that instruction is
// complete; the cycle that carries instr_valid may already carry cu_done. A cu_done pulse with
// no instruction outstanding is ignored. Program memory is a combinational read of imem_addr.
interface instr_sequencer_if #(
    parameter int IW = 17,
    parameter int AW = 5,
    parameter int FW = 5
);
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          cu_done;
    logic [FW-1:0] flag;

    // Sequencer side.
    modport master (
        output imem_addr,
        input  imem_data,
        output instr,
        output instr_valid,
        input  cu_done,
        input  flag
    );

    // Program memory / control unit side.
    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr,
        input  instr_valid,
        output cu_done,
        output flag
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue controller for the 17-bit core. Owns the program counter, fetches from program
// memory, resolves flag branches locally and hands all other instructions to the cu.
// Optional feature: define INSTR_SEQ_TIMEOUT_EN to bound the WAIT state with a timeout that
// sets a sticky err and halts. Without it WAIT is unbounded and err is tied low.
// Debug: dbg_state_o exposes the FSM state (IDLE=0 FETCH=1 DECODE=2 ISSUE=3 WAIT=4 HALT=5).
module instr_sequencer #(
    parameter int         IW          = 17,
    parameter int         AW          = 5,
    parameter int         FW          = 5,
    parameter int         PROG_LEN    = 9,
    parameter logic [4:0] OPC_BR      = 5'b11111,
    parameter int         TIMEOUT_CYC = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_sequencer_if.master   bus,
    output logic [AW-1:0]       pc,
    output logic                busy,
    output logic                halted,
    output logic                err,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // End-of-program compare is done one bit wider than pc so that PROG_LEN == 2**AW works:
    // pc+1 wrapping past the top then shows up as pc_inc == PROG_END rather than as 0.
    localparam logic [AW:0] PROG_END = (AW+1)'(PROG_LEN);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;

    // Branch word layout: [16:12] opcode, [11:9] flag index, [8:4] target, [3:0] unused.
    logic          is_branch;
    logic [2:0]    br_idx;
    logic [AW-1:0] br_tgt;
    logic          br_flag;
    logic [AW:0]   pc_inc;
    logic [AW:0]   br_next;

`ifdef INSTR_SEQ_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
    // Last count value at which a further idle WAIT cycle means the timeout has been reached.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Branch decode and next-pc candidates, all from the registered instruction.
    always_comb begin
        is_branch = (instr_q[IW-1 -: 5] == OPC_BR);
        br_idx    = instr_q[11:9];
        br_tgt    = instr_q[4 +: AW];
        br_flag   = 1'b0;
        for (int i = 0; i < FW; i++) begin
            if (int'(br_idx) == i) begin
                br_flag = bus.flag[i];
            end
        end
        pc_inc  = {1'b0, pc_q} + (AW+1)'(1);
        // Flag clear means the branch is taken.
        br_next = br_flag ? pc_inc : {1'b0, br_tgt};
    end

    // State register and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
`ifdef INSTR_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef INSTR_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef INSTR_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = bus.imem_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_branch) begin
                    // Branches never reach the cu; an out-of-range target halts with pc parked on it.
                    pc_d    = br_next[AW-1:0];
                    state_d = (br_next >= PROG_END) ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef INSTR_SEQ_TIMEOUT_EN
                cnt_d = '0;
`endif
                // A cu that finishes in the issue cycle itself skips WAIT.
                if (bus.cu_done) begin
                    pc_d    = pc_inc[AW-1:0];
                    state_d = (pc_inc >= PROG_END) ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (bus.cu_done) begin
                    pc_d    = pc_inc[AW-1:0];
                    state_d = (pc_inc >= PROG_END) ? S_HALT : S_FETCH;
                end
`ifdef INSTR_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = '0;
`ifdef INSTR_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        bus.instr_valid = (state_q == S_ISSUE);
        busy            = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                          (state_q == S_ISSUE) || (state_q == S_WAIT);
        halted          = (state_q == S_HALT);
    end

    assign bus.imem_addr = pc_q;
    assign bus.instr     = instr_q;
    assign pc            = pc_q;
    assign dbg_state_o   = state_q;

`ifdef INSTR_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
